// File: rtl/otter_fetch_stage_if.sv
// otter_fetch_stage_if
//   Bundles the fetch stage's control inputs, instruction-memory port 1 and
//   IF/ID pipeline-register outputs.
//   master : fetch stage side (drives IMEM_ADDR/IMEM_RD and the IF_ID_* outputs)
//   slave  : environment side (hazard unit, execute redirect, memory, decode)
//   Signals:
//     STALL, FLUSH, REDIRECT_PC[31:0]          control from hazard unit / execute
//     IMEM_ADDR[31:0], IMEM_RD, IMEM_DOUT[31:0] memory port 1
//     IF_ID_PC, IF_ID_PC4, IF_ID_IR, IF_ID_VALID IF/ID register to decode
//     FETCH_MISALIGN                            only with OTTER_FETCH_MISALIGN_EN
interface otter_fetch_stage_if;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] REDIRECT_PC;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD;
    logic [31:0] IMEM_DOUT;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_IR;
    logic        IF_ID_VALID;
`ifdef OTTER_FETCH_MISALIGN_EN
    logic        FETCH_MISALIGN;

    modport master (
        input  STALL, FLUSH, REDIRECT_PC, IMEM_DOUT,
        output IMEM_ADDR, IMEM_RD, IF_ID_PC, IF_ID_PC4, IF_ID_IR, IF_ID_VALID,
        output FETCH_MISALIGN
    );
    modport slave (
        output STALL, FLUSH, REDIRECT_PC, IMEM_DOUT,
        input  IMEM_ADDR, IMEM_RD, IF_ID_PC, IF_ID_PC4, IF_ID_IR, IF_ID_VALID,
        input  FETCH_MISALIGN
    );
`else
    modport master (
        input  STALL, FLUSH, REDIRECT_PC, IMEM_DOUT,
        output IMEM_ADDR, IMEM_RD, IF_ID_PC, IF_ID_PC4, IF_ID_IR, IF_ID_VALID
    );
    modport slave (
        output STALL, FLUSH, REDIRECT_PC, IMEM_DOUT,
        input  IMEM_ADDR, IMEM_RD, IF_ID_PC, IF_ID_PC4, IF_ID_IR, IF_ID_VALID
    );
`endif
endinterface

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage
//   Pipelined instruction-fetch stage of the OTTER RV32I core. Owns the PC,
//   drives synchronous-read memory port 1 (1-cycle latency) and presents the
//   fetched instruction, its PC and PC+4 as the IF/ID register.
//   Ports:
//     CLK  - system clock, rising edge
//     RST  - asynchronous active-high reset
//     bus  - otter_fetch_stage_if.master (control, memory port, IF/ID outputs)
//   Parameters:
//     RESET_VEC - first fetch address after reset (word aligned)
//     NOP_INSTR - word presented while IF/ID holds no live instruction
//   Optional: define OTTER_FETCH_MISALIGN_EN to add the registered
//   FETCH_MISALIGN flag for redirects with REDIRECT_PC[1:0] != 0.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                CLK,
    input  logic                RST,
    otter_fetch_stage_if.master bus
);

    logic [31:0] pc_q;        // next sequential fetch address
    logic [31:0] d_pc;        // PC of the instruction whose data is on IMEM_DOUT
    logic        d_valid;
    logic        held;        // hold_ir holds the presented word (memory not re-read)
    logic [31:0] hold_ir;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = bus.REDIRECT_PC & 32'hFFFF_FFFC;

    // Priority FLUSH > STALL > advance. A flush fetches the target in the same
    // cycle, so the redirected instruction is presented on the next cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= RESET_VEC;
            d_pc    <= RESET_VEC;
            d_valid <= 1'b0;
            held    <= 1'b0;
            hold_ir <= '0;
        end else if (bus.FLUSH) begin
            d_pc    <= redirect_aligned;
            d_valid <= 1'b1;
            pc_q    <= redirect_aligned + 32'd4;
            held    <= 1'b0;
        end else if (bus.STALL) begin
            // Memory output is only valid for one cycle; capture it on the
            // first stalled edge so IF_ID_IR stays stable for the whole stall.
            if (!held) begin
                hold_ir <= bus.IMEM_DOUT;
                held    <= 1'b1;
            end
        end else begin
            d_pc    <= pc_q;
            d_valid <= 1'b1;
            pc_q    <= pc_q + 32'd4;
            held    <= 1'b0;
        end
    end

`ifdef OTTER_FETCH_MISALIGN_EN
    logic misalign_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.FLUSH & (|bus.REDIRECT_PC[1:0]);
        end
    end

    assign bus.FETCH_MISALIGN = misalign_q;
`endif

    always_comb begin
        bus.IMEM_ADDR   = pc_q;
        bus.IMEM_RD     = 1'b0;
        bus.IF_ID_VALID = 1'b0;
        bus.IF_ID_IR    = NOP_INSTR;
        bus.IF_ID_PC    = d_pc;
        bus.IF_ID_PC4   = d_pc + 32'd4;

        if (bus.FLUSH) begin
            bus.IMEM_ADDR = redirect_aligned;
        end
        bus.IMEM_RD     = ~RST & (bus.FLUSH | ~bus.STALL);
        bus.IF_ID_VALID = d_valid & ~bus.FLUSH;
        if (d_valid) begin
            bus.IF_ID_IR = held ? hold_ir : bus.IMEM_DOUT;
        end
    end

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic CLK;
    logic RST;
    logic scramble;
    int   checks;
    int   errors;

    otter_fetch_stage_if f_if ();
    otter_fetch_stage_if w_if ();

    otter_fetch_stage #(
        .RESET_VEC (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (f_if.master)
    );

    // Second instance only exercises PC wrap-around from a high reset vector.
    otter_fetch_stage #(
        .RESET_VEC (32'hFFFF_FFF8),
        .NOP_INSTR (NOP)
    ) dut_wrap (
        .CLK (CLK),
        .RST (RST),
        .bus (w_if.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read memory: word = address ^ SALT; garbage while scrambled.
    always @(posedge CLK) begin
        if (scramble)
            f_if.IMEM_DOUT <= $urandom;
        else if (f_if.IMEM_RD)
            f_if.IMEM_DOUT <= f_if.IMEM_ADDR ^ SALT;
    end

    assign w_if.IMEM_DOUT   = 32'h1234_5678;
    assign w_if.STALL       = 1'b0;
    assign w_if.FLUSH       = 1'b0;
    assign w_if.REDIRECT_PC = 32'h0;

    // Reference: which PC is on display, whether it is a real fetch, and the
    // next sequential address. The word for a PC is always PC ^ SALT.
    logic [31:0] m_pc, m_next;
    logic        m_live, m_mis;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pc   = 32'h0;
            m_next = 32'h0;
            m_live = 1'b0;
            m_mis  = 1'b0;
        end else begin
            m_mis = f_if.FLUSH && (f_if.REDIRECT_PC[1:0] != 2'b00);
            if (f_if.FLUSH) begin
                m_pc   = {f_if.REDIRECT_PC[31:2], 2'b00};
                m_next = m_pc + 32'd4;
                m_live = 1'b1;
            end else if (!f_if.STALL) begin
                m_pc   = m_next;
                m_next = m_next + 32'd4;
                m_live = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_rd",    {31'b0, f_if.IMEM_RD},     32'h0);
            chk("rst_valid", {31'b0, f_if.IF_ID_VALID}, 32'h0);
            chk("rst_ir",    f_if.IF_ID_IR,             NOP);
            chk("rst_pc",    f_if.IF_ID_PC,             32'h0);
            chk("rst_pc4",   f_if.IF_ID_PC4,            32'h4);
        end else begin
            chk("m_valid", {31'b0, f_if.IF_ID_VALID}, {31'b0, m_live & ~f_if.FLUSH});
            chk("m_pc",    f_if.IF_ID_PC,  m_pc);
            chk("m_pc4",   f_if.IF_ID_PC4, m_pc + 32'd4);
            chk("m_ir",    f_if.IF_ID_IR,  m_live ? (m_pc ^ SALT) : NOP);
            chk("m_rd",    {31'b0, f_if.IMEM_RD}, {31'b0, f_if.FLUSH | ~f_if.STALL});
            chk("m_addr",  f_if.IMEM_ADDR,
                f_if.FLUSH ? {f_if.REDIRECT_PC[31:2], 2'b00} : m_next);
`ifdef OTTER_FETCH_MISALIGN_EN
            chk("m_mis",   {31'b0, f_if.FETCH_MISALIGN}, {31'b0, m_mis});
`endif
        end
    end

    // Advance one clock, apply this cycle's inputs, let outputs settle.
    task automatic cyc(input logic st, input logic fl, input logic [31:0] rpc, input logic scr);
        @(posedge CLK);
        #1;
        f_if.STALL       = st;
        f_if.FLUSH       = fl;
        f_if.REDIRECT_PC = rpc;
        scramble         = scr;
        #1;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        RST              = 1'b1;
        scramble         = 1'b0;
        f_if.STALL       = 1'b0;
        f_if.FLUSH       = 1'b0;
        f_if.REDIRECT_PC = 32'h0;
        f_if.IMEM_DOUT   = 32'h0;

        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("reset_ir",   dut_wrap.bus.IF_ID_IR,  NOP);
        chk("reset_wpc",  w_if.IF_ID_PC,  32'hFFFF_FFF8);
        chk("reset_wpc4", w_if.IF_ID_PC4, 32'hFFFF_FFFC);
        RST = 1'b0;
        #1;
        // cycle 0: fetch of RESET_VEC issued, nothing presented yet
        chk("c0_valid", {31'b0, f_if.IF_ID_VALID}, 32'h0);
        chk("c0_rd",    {31'b0, f_if.IMEM_RD},     32'h1);
        chk("c0_addr",  f_if.IMEM_ADDR,            32'h0);

        cyc(0, 0, 0, 0);   // cycle 1
        chk("c1_valid", {31'b0, f_if.IF_ID_VALID}, 32'h1);
        chk("c1_pc",  f_if.IF_ID_PC, 32'h0);
        chk("c1_ir",  f_if.IF_ID_IR, 32'hA5A5_0000);
        chk("c1_wpc", w_if.IF_ID_PC, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0);   // cycle 2
        chk("c2_pc",   f_if.IF_ID_PC,  32'h4);
        chk("c2_wpc",  w_if.IF_ID_PC,  32'hFFFF_FFFC);
        chk("c2_wpc4", w_if.IF_ID_PC4, 32'h0);
        cyc(1, 0, 0, 1);   // cycle 3: stall begins, memory scrambled
        chk("c3_pc",  f_if.IF_ID_PC, 32'h8);
        chk("c3_ir",  f_if.IF_ID_IR, 32'hA5A5_0008);
        chk("c3_rd",  {31'b0, f_if.IMEM_RD}, 32'h0);
        chk("c3_wpc", w_if.IF_ID_PC, 32'h0);
        cyc(1, 0, 0, 1);   // cycle 4
        chk("c4_ir",  f_if.IF_ID_IR, 32'hA5A5_0008);
        cyc(1, 0, 0, 1);   // cycle 5
        chk("c5_ir",  f_if.IF_ID_IR, 32'hA5A5_0008);
        chk("c5_pc",  f_if.IF_ID_PC, 32'h8);
        cyc(0, 0, 0, 0);   // cycle 6: release
        chk("c6_ir",   f_if.IF_ID_IR,  32'hA5A5_0008);
        chk("c6_addr", f_if.IMEM_ADDR, 32'hC);
        cyc(0, 0, 0, 0);   // cycle 7
        chk("c7_pc",  f_if.IF_ID_PC, 32'hC);
        chk("c7_ir",  f_if.IF_ID_IR, 32'hA5A5_000C);
        cyc(0, 1, 32'h100, 0);   // cycle 8: flush while PC=0x10
        chk("c8_pc",    f_if.IF_ID_PC, 32'h10);
        chk("c8_valid", {31'b0, f_if.IF_ID_VALID}, 32'h0);
        chk("c8_addr",  f_if.IMEM_ADDR, 32'h100);
        cyc(1, 0, 0, 1);   // cycle 9: redirected instruction, then stall
        chk("c9_pc",  f_if.IF_ID_PC,  32'h100);
        chk("c9_pc4", f_if.IF_ID_PC4, 32'h104);
        chk("c9_ir",  f_if.IF_ID_IR,  32'hA5A5_0100);
        cyc(1, 1, 32'h40, 0);    // cycle 10: flush + stall with held=1
        chk("c10_ir",   f_if.IF_ID_IR, 32'hA5A5_0100);
        chk("c10_rd",   {31'b0, f_if.IMEM_RD}, 32'h1);
        chk("c10_addr", f_if.IMEM_ADDR, 32'h40);
        cyc(0, 1, 32'h200, 0);   // cycle 11
        chk("c11_pc", f_if.IF_ID_PC, 32'h40);
        chk("c11_ir", f_if.IF_ID_IR, 32'hA5A5_0040);
        cyc(0, 1, 32'h300, 0);   // cycle 12
        chk("c12_pc", f_if.IF_ID_PC, 32'h200);
        cyc(0, 1, 32'h102, 0);   // cycle 13: misaligned redirect
        chk("c13_pc",   f_if.IF_ID_PC, 32'h300);
        chk("c13_ir",   f_if.IF_ID_IR, 32'hA5A5_0300);
        chk("c13_addr", f_if.IMEM_ADDR, 32'h100);
        cyc(0, 0, 0, 0);   // cycle 14
        chk("c14_pc", f_if.IF_ID_PC, 32'h100);
        chk("c14_ir", f_if.IF_ID_IR, 32'hA5A5_0100);
`ifdef OTTER_FETCH_MISALIGN_EN
        chk("c14_mis", {31'b0, f_if.FETCH_MISALIGN}, 32'h1);
`endif
        cyc(0, 1, 32'h204, 0);   // cycle 15
`ifdef OTTER_FETCH_MISALIGN_EN
        chk("c15_mis", {31'b0, f_if.FETCH_MISALIGN}, 32'h0);
`endif
        chk("c15_pc", f_if.IF_ID_PC, 32'h104);
        cyc(1, 0, 0, 1);   // cycle 16
        chk("c16_pc", f_if.IF_ID_PC, 32'h204);
        cyc(1, 0, 0, 1);   // cycle 17: reset mid-stall
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_pc",    f_if.IF_ID_PC, 32'h0);
        chk("mrst_valid", {31'b0, f_if.IF_ID_VALID}, 32'h0);
        chk("mrst_rd",    {31'b0, f_if.IMEM_RD}, 32'h0);
        chk("mrst_ir",    f_if.IF_ID_IR, NOP);
        @(posedge CLK);
        #1;
        f_if.STALL = 1'b0;
        f_if.FLUSH = 1'b0;
        scramble   = 1'b0;
        RST        = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic st, fl;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 5) == 0);
            cyc(st, fl, $urandom_range(0, 32'h0000_FFFF), st & ~fl);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
